dummy_accelerator_issuer: RTL and testbench

// - Core-side initiator for the dummy accelerator: accepts ops from the core, tags and sends them to the accelerator.
// - Collects tagged results that may return out of order, reorders them in a DEPTH-entry ROB, writes back in program order.
// - A flush invalidates all in-flight ops; late results from before the flush are dropped via an epoch bit carried in the tag.

---
 rtl/dummy_accelerator_issuer.sv | 149 ++++++++++++++
 tb/tb_dummy_accelerator_issuer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_issuer.sv
// Core-side issuer for the dummy accelerator: tags ops, reorders results in a ROB, writes back in order.
// Optional head watchdog enabled with `define ACC_ISSUER_TIMEOUT_EN.
module dummy_accelerator_issuer #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 11,
  parameter int RD_WIDTH  = 5,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 256,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int TAG_W    = IDX_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [WIDTH-1:0]     issue_rs1_i,
  input  logic [IMM_WIDTH-1:0] issue_imm_i,
  input  logic [RD_WIDTH-1:0]  issue_rd_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [WIDTH-1:0]     acc_rs1_o,
  output logic [IMM_WIDTH-1:0] acc_imm_o,
  output logic [TAG_W-1:0]     acc_tag_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [WIDTH-1:0]     res_data_i,
  input  logic [TAG_W-1:0]     res_tag_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [RD_WIDTH-1:0]  wb_rd_o,
  output logic [WIDTH-1:0]     wb_data_o,
  output logic                 wb_err_o,
  output logic                 spurious_o
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  logic [DEPTH-1:0]    alloc_q, done_q;
  logic [RD_WIDTH-1:0] rd_q   [DEPTH];
  logic [WIDTH-1:0]    data_q [DEPTH];
  logic [IDX_W-1:0]    head_q, tail_q;
  logic [IDX_W:0]      count_q;
  logic                epoch_q;
  logic                spurious_q;

  logic             full, issue_fire, retire, res_accept, wd_expire;
  logic [IDX_W-1:0] res_idx;
  logic             res_epoch;

  assign full          = (count_q == DEPTH_C);
  assign acc_valid_o   = issue_valid_i & ~full & ~flush_i;
  assign issue_ready_o = acc_ready_i & ~full & ~flush_i;
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign acc_rs1_o     = issue_rs1_i;
  assign acc_imm_o     = issue_imm_i;
  assign acc_tag_o     = {epoch_q, tail_q};
  assign res_ready_o   = 1'b1;

  // A result lands only if it belongs to the current epoch and targets a still-pending entry
  assign res_idx    = res_tag_i[IDX_W-1:0];
  assign res_epoch  = res_tag_i[IDX_W];
  assign res_accept = res_valid_i & ~flush_i & (res_epoch == epoch_q)
                    & alloc_q[res_idx] & ~done_q[res_idx];

  assign wb_valid_o = alloc_q[head_q] & done_q[head_q];
  assign wb_rd_o    = rd_q[head_q];
  assign wb_data_o  = data_q[head_q];
  assign retire     = wb_valid_o & wb_ready_i & ~flush_i;
  assign spurious_o = spurious_q;

`ifdef ACC_ISSUER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]  wd_q;
  logic [DEPTH-1:0] err_q;
  logic             wd_run;

  assign wd_run    = alloc_q[head_q] & ~done_q[head_q];
  // A real result arriving for the head in the expiry cycle wins over the timeout
  assign wd_expire = wd_run & (wd_q == WD_W'(TIMEOUT - 1)) & ~flush_i
                   & ~(res_accept & (res_idx == head_q));
  assign wb_err_o  = wb_valid_o & err_q[head_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= '0;
    end else if (flush_i) begin
      wd_q  <= '0;
      err_q <= '0;
    end else begin
      if (retire || wd_expire || !wd_run) wd_q <= '0;
      else                                wd_q <= wd_q + 1'b1;
      if (issue_fire) err_q[tail_q] <= 1'b0;
      if (wd_expire)  err_q[head_q] <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wb_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      epoch_q    <= 1'b0;
      spurious_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      spurious_q <= res_valid_i & ~res_accept;
      if (flush_i) begin
        alloc_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        epoch_q <= ~epoch_q;
      end else begin
        if (issue_fire) begin
          alloc_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          rd_q[tail_q]    <= issue_rd_i;
          tail_q          <= tail_q + 1'b1;
        end
        if (res_accept) begin
          data_q[res_idx] <= res_data_i;
          done_q[res_idx] <= 1'b1;
        end
        if (wd_expire) begin
          data_q[head_q] <= '0;
          done_q[head_q] <= 1'b1;
        end
        if (retire) begin
          alloc_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        count_q <= count_q + (IDX_W + 1)'(issue_fire) - (IDX_W + 1)'(retire);
      end
    end
  end

endmodule

// File: tb/tb_dummy_accelerator_issuer.sv
// Scoreboard bench for dummy_accelerator_issuer: in-order writeback, full/backpressure, flush/epoch, spurious drops.
module tb_dummy_accelerator_issuer;

  localparam int W  = 32;
  localparam int IW = 11;
  localparam int RW = 5;
  localparam int D  = 4;
`ifdef ACC_ISSUER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, issue_valid, issue_ready, acc_valid, acc_ready;
  logic [W-1:0]  issue_rs1, acc_rs1, res_data, wb_data;
  logic [IW-1:0] issue_imm, acc_imm;
  logic [RW-1:0] issue_rd, wb_rd;
  logic [2:0]    acc_tag, res_tag;
  logic          res_valid, res_ready, wb_valid, wb_ready, wb_err, spurious;

  typedef struct packed {
    logic          err;
    logic [RW-1:0] rd;
    logic [W-1:0]  data;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] slot_data [D];
  logic         exp_epoch;
  logic [1:0]   exp_tail, exp_head;
  int           checks, errors;

  always #5 clk = ~clk;

  dummy_accelerator_issuer #(
    .WIDTH(W), .IMM_WIDTH(IW), .RD_WIDTH(RW), .DEPTH(D), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_rs1_i(issue_rs1), .issue_imm_i(issue_imm), .issue_rd_i(issue_rd),
    .acc_valid_o(acc_valid), .acc_ready_i(acc_ready),
    .acc_rs1_o(acc_rs1), .acc_imm_o(acc_imm), .acc_tag_o(acc_tag),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_data_i(res_data), .res_tag_i(res_tag),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_err_o(wb_err),
    .spurious_o(spurious)
  );

  // Writeback monitor: every handshake must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready && !flush) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: rd=%0d data=%h with empty scoreboard", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        exp_head = exp_head + 1'b1;
        if (wb_rd !== e.rd || wb_data !== e.data || wb_err !== e.err) begin
          errors++;
          $display("FAIL wb_order: got rd=%0d data=%h err=%b, required rd=%0d data=%h err=%b",
                   wb_rd, wb_data, wb_err, e.rd, e.data, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [RW-1:0] rd, input logic [W-1:0] data, input logic err);
    logic [W-1:0]  rs1;
    logic [IW-1:0] imm;
    exp_t          e;
    rs1 = $urandom;
    imm = IW'($urandom);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_imm = imm; issue_rd = rd;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL issue_handshake: ready=%b valid=%b, required 1/1", issue_ready, acc_valid);
    end
    checks++;
    if (acc_tag !== {exp_epoch, exp_tail}) begin
      errors++;
      $display("FAIL acc_tag: got %b, required %b", acc_tag, {exp_epoch, exp_tail});
    end
    checks++;
    if (acc_rs1 !== rs1 || acc_imm !== imm) begin
      errors++;
      $display("FAIL acc_passthrough: got %h/%h, required %h/%h", acc_rs1, acc_imm, rs1, imm);
    end
    @(posedge clk);
    e.err = err; e.rd = rd; e.data = err ? '0 : data;
    q.push_back(e);
    slot_data[exp_tail] = data;
    exp_tail = exp_tail + 1'b1;
    #1 issue_valid = 1'b0;
  endtask

  task automatic send_res(input logic ep, input logic [1:0] idx, input logic [W-1:0] data);
    res_valid = 1'b1; res_tag = {ep, idx}; res_data = data;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writebacks outstanding, required 0", q.size());
    end
  endtask

  task automatic send_shuffled(input logic [1:0] idxs_in [4], input int n);
    logic [1:0] idxs [4];
    idxs = idxs_in;
    for (int k = n - 1; k > 0; k--) begin
      int j;
      logic [1:0] t;
      j = $urandom_range(k, 0);
      t = idxs[k]; idxs[k] = idxs[j]; idxs[j] = t;
    end
    for (int k = 0; k < n; k++) send_res(exp_epoch, idxs[k], slot_data[idxs[k]]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || acc_valid !== 1'b0 || wb_valid !== 1'b0 || wb_err !== 1'b0
        || spurious !== 1'b0 || acc_tag !== 3'b000 || res_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rdy=%b av=%b wbv=%b err=%b sp=%b tag=%b rr=%b, required 1 0 0 0 0 000 1",
               issue_ready, acc_valid, wb_valid, wb_err, spurious, acc_tag, res_ready);
    end
    issue_valid = 1'b1;
    #1;
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_acc_valid: got %b, required 1", acc_valid);
    end
    issue_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reorder();
    wb_ready = 1'b1;
    issue_op(5'd1, 32'hA000_0001, 1'b0);
    issue_op(5'd2, 32'hA000_0002, 1'b0);
    issue_op(5'd3, 32'hA000_0003, 1'b0);
    send_res(exp_epoch, 2'd2, slot_data[2]);
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL reorder_wait_head: wb_valid=%b spurious=%b, required 0/0", wb_valid, spurious);
    end
    tick();
    send_res(exp_epoch, 2'd0, slot_data[0]);
    send_res(exp_epoch, 2'd1, slot_data[1]);
    drain();
  endtask

  task automatic test_full();
    wb_ready = 1'b0;
    for (int i = 0; i < D; i++) issue_op(RW'(i + 4), $urandom, 1'b0);
    issue_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_block: ready=%b valid=%b, required 0/0", issue_ready, acc_valid);
    end
    tick();
    issue_valid = 1'b0;
    send_res(exp_epoch, exp_head, slot_data[exp_head]);
    wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_retire_cycle: wb_valid=%b ready=%b, required 1/0", wb_valid, issue_ready);
    end
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_retire: ready=%b, required 1", issue_ready);
    end
    tick();
  endtask

  task automatic test_hold();
    exp_t e;
    wb_ready = 1'b0;
    send_res(exp_epoch, exp_head, slot_data[exp_head]);
    e = q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== e.rd || wb_data !== e.data) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: v=%b rd=%0d data=%h, required 1 %0d %h",
                 i, wb_valid, wb_rd, wb_data, e.rd, e.data);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [1:0] old_idx;
    old_idx = exp_head;
    send_res(exp_epoch, exp_head + 2'd1, slot_data[exp_head + 2'd1]);
    wb_ready = 1'b1; issue_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (acc_valid !== 1'b0 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate: valid=%b ready=%b, required 0/0", acc_valid, issue_ready);
    end
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    q.delete();
    exp_epoch = ~exp_epoch; exp_tail = '0; exp_head = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || acc_tag !== {exp_epoch, 2'd0}) begin
      errors++;
      $display("FAIL flush_state: wb_valid=%b tag=%b, required 0 %b", wb_valid, acc_tag, {exp_epoch, 2'd0});
    end
    tick();
    send_res(~exp_epoch, old_idx, 32'hBAD0_0000);
    @(negedge clk);
    checks++;
    if (spurious !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: spurious=%b wb_valid=%b, required 1/0", spurious, wb_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL spurious_pulse_width: spurious=%b, required 0", spurious);
    end
    tick();
    issue_op(5'd9, $urandom, 1'b0);
    send_res(exp_epoch, 2'd0, slot_data[0]);
    drain();
  endtask

  task automatic test_spurious();
    wb_ready = 1'b0;
    send_res(exp_epoch, exp_tail + 2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (spurious !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_unalloc: spurious=%b wb_valid=%b, required 1/0", spurious, wb_valid);
    end
    tick();
    issue_op(5'd10, 32'h1111_2222, 1'b0);
    send_res(exp_epoch, exp_head, 32'h1111_2222);
    send_res(exp_epoch, exp_head, 32'h3333_4444);
    @(negedge clk);
    checks++;
    if (spurious !== 1'b1 || wb_valid !== 1'b1 || wb_data !== 32'h1111_2222) begin
      errors++;
      $display("FAIL spurious_done: sp=%b v=%b data=%h, required 1 1 11112222", spurious, wb_valid, wb_data);
    end
    tick();
    wb_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] idxs [4];
    wb_ready = 1'b1;
    issue_op(5'd11, $urandom, 1'b0);
    idxs[0] = exp_tail;
    issue_op(5'd12, $urandom, 1'b0);
    send_res(exp_epoch, exp_head, slot_data[exp_head]);
    for (int i = 1; i < D; i++) begin
      idxs[i] = exp_tail;
      issue_op(RW'(12 + i), $urandom, 1'b0);
    end
    issue_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: ready=%b, required 0 with ROB full", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    send_shuffled(idxs, D);
    drain();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(D, 1);
      for (int k = 0; k < n; k++) begin
        idxs[k] = exp_tail;
        issue_op(RW'($urandom), $urandom, 1'b0);
      end
      send_shuffled(idxs, n);
      drain();
    end
  endtask

`ifdef ACC_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] idx;
    int lat;
    wb_ready = 1'b0;
    idx = exp_tail;
    issue_op(5'd7, 32'h0000_FFFF, 1'b1);
    lat = 0;
    while (wb_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required 8", lat);
    end
    @(negedge clk);
    checks++;
    if (wb_err !== 1'b1 || wb_data !== '0) begin
      errors++;
      $display("FAIL timeout_err: err=%b data=%h, required 1 0", wb_err, wb_data);
    end
    tick();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    send_res(exp_epoch, idx, 32'h0000_FFFF);
    @(negedge clk);
    checks++;
    if (spurious !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_res: spurious=%b wb_valid=%b, required 1/0", spurious, wb_valid);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    exp_epoch = ~exp_epoch; exp_tail = '0; exp_head = '0;
    wb_ready = 1'b0;
    issue_op(5'd20, $urandom, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (acc_tag !== 3'b000 || wb_valid !== 1'b0 || issue_ready !== 1'b1 || spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tag=%b wb_valid=%b ready=%b sp=%b, required 000 0 1 0",
               acc_tag, wb_valid, issue_ready, spurious);
    end
    q.delete();
    exp_epoch = 1'b0; exp_tail = '0; exp_head = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    wb_ready = 1'b1;
    issue_op(5'd21, $urandom, 1'b0);
    send_res(exp_epoch, 2'd0, slot_data[0]);
    drain();
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_epoch = 1'b0; exp_tail = '0; exp_head = '0;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; acc_ready = 1'b1;
    issue_rs1 = '0; issue_imm = '0; issue_rd = '0;
    res_valid = 1'b0; res_data = '0; res_tag = '0; wb_ready = 1'b0;
    test_reset();
    test_reorder();
`ifdef ACC_ISSUER_TIMEOUT_EN
    test_timeout();
`else
    test_full();
    test_hold();
    test_flush();
    test_spurious();
    test_back_to_back();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
